// File: rtl/inst_loader.sv
// Instruction-memory program loader: packs a big-endian UART byte stream into 32-bit words.
// Optional trailing XOR checksum byte after HALT is enabled by defining INST_LOADER_CHECKSUM_EN.
module inst_loader #(
  parameter int unsigned     B    = 32,
  parameter int unsigned     W    = 5,
  parameter int unsigned     PC   = 32,
  parameter logic [B-1:0]    HALT = 32'hFFFF_FFFF
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_valid,
  output logic          o_write,
  output logic [PC-1:0] o_addr,
  output logic [B-1:0]  o_data,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_error,
  output logic [W:0]    o_count
);

`ifdef INST_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif

  state_t       state;
  logic [W-1:0] idx;
  logic [1:0]   bcnt;
  logic [B-9:0] asm_q;   // first three bytes of the word under assembly
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]   csum;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= IDLE;
      idx     <= '0;
      bcnt    <= '0;
      asm_q   <= '0;
      o_write <= 1'b0;
      o_addr  <= '0;
      o_data  <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_error <= 1'b0;
      o_count <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum    <= '0;
`endif
    end else begin
      o_write <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            state   <= RECV;
            idx     <= '0;
            bcnt    <= '0;
            o_count <= '0;
            o_error <= 1'b0;
            o_busy  <= 1'b1;
            o_done  <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            csum    <= '0;
`endif
          end
        end
        RECV: begin
          if (i_rx_valid) begin
            asm_q <= {asm_q[B-17:0], i_rx_data};
            bcnt  <= bcnt + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
            csum  <= csum ^ i_rx_data;
`endif
            if (bcnt == 2'd3) begin
              o_data  <= {asm_q, i_rx_data};
              o_addr  <= {{(PC-W-2){1'b0}}, idx, 2'b00};
              o_write <= 1'b1;
              state   <= WRITE;
            end
          end
        end
        WRITE: begin
          idx     <= idx + W'(1);
          o_count <= o_count + (W+1)'(1);
          if (o_data == HALT) begin
`ifdef INST_LOADER_CHECKSUM_EN
            // A byte landing in the HALT write cycle is already the checksum byte.
            if (i_rx_valid) begin
              o_error <= (i_rx_data != csum);
              state   <= DONE;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
            end else begin
              state <= CHECK;
            end
`else
            state  <= DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
`endif
          end else if (idx == '1) begin
            o_error <= 1'b1;
            state   <= DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
          end else begin
            state <= RECV;
            // bcnt has wrapped to 0, so this byte opens the next word.
            if (i_rx_valid) begin
              asm_q <= {asm_q[B-17:0], i_rx_data};
              bcnt  <= bcnt + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
              csum  <= csum ^ i_rx_data;
`endif
            end
          end
        end
`ifdef INST_LOADER_CHECKSUM_EN
        CHECK: begin
          if (i_rx_valid) begin
            o_error <= (i_rx_data != csum);
            state   <= DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
